// File: rtl/keypad_debouncer.sv
// Keypad front end: 2-flop synchroniser, debounce FSM and lowest-index encoder.
// Produces one keystrobe per accepted press, with the keycode held until the next press.
module keypad_debouncer #(
   parameter int NKEYS     = 13,
   parameter int DB_CYCLES = 4,
   localparam int KW       = $clog2(NKEYS),
   localparam int CW       = $clog2(DB_CYCLES)
) (
   input  logic             hwclk_i,
   input  logic             reset_i,
   input  logic [NKEYS-1:0] pb_i,
   output logic [KW-1:0]    keycode_o,
   output logic             keystrobe_o,
   output logic             key_held_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   // Scanning from the top down lets the lowest set bit win.
   function automatic logic [KW-1:0] enc_lowest(input logic [NKEYS-1:0] v);
      logic [KW-1:0] idx;
      idx = '0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = KW'(i);
         end
      end
      return idx;
   endfunction

   logic [NKEYS-1:0] sync1_q;
   logic [NKEYS-1:0] sync2_q;
   logic [NKEYS-1:0] vec_q;
   logic [CW-1:0]    cnt_q;
   state_t           state_q;
   logic [KW-1:0]    keycode_q;
   logic [KW-1:0]    keycode_d;
   logic             keystrobe_q;
   logic             key_held_q;

   assign keycode_d = enc_lowest(vec_q);

   // Two-flop synchroniser for the asynchronous pushbuttons.
   always_ff @(posedge hwclk_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pb_i;
         sync2_q <= sync1_q;
      end
   end

   // Debounce FSM with registered keycode, strobe and held outputs.
   always_ff @(posedge hwclk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         vec_q       <= '0;
         keycode_q   <= '0;
         keystrobe_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         keystrobe_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sync2_q != '0) begin
                  state_q <= ST_DEBOUNCE;
                  vec_q   <= sync2_q;
                  cnt_q   <= '0;
               end
            end
            ST_DEBOUNCE: begin
               if (sync2_q == '0) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (sync2_q != vec_q) begin
                  vec_q <= sync2_q;
                  cnt_q <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= ST_PRESSED;
                  cnt_q       <= '0;
                  keycode_q   <= keycode_d;
                  keystrobe_q <= 1'b1;
                  key_held_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_PRESSED: begin
               if (sync2_q == '0) begin
                  state_q <= ST_RELEASE;
                  cnt_q   <= '0;
               end
            end
            // Any renewed activity during release is bounce, never a new press.
            ST_RELEASE: begin
               if (sync2_q != '0) begin
                  state_q <= ST_PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q    <= ST_IDLE;
                  cnt_q      <= '0;
                  key_held_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               cnt_q      <= '0;
               key_held_q <= 1'b0;
            end
         endcase
      end
   end

   assign keycode_o   = keycode_q;
   assign keystrobe_o = keystrobe_q;
   assign key_held_o  = key_held_q;

endmodule
